// File: rtl/csr_hpm_pkg.sv
// Shared constants and types for the machine counter / HPM CSR bank.
package csr_hpm_pkg;

   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCNT_BASE  = 12'hB03;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_HPMCNT_BASE   = 12'hC03;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MHPMEVT_BASE  = 12'h323;

   localparam int EVT_SEL_W  = 8;
   localparam int EVT_OF_BIT = 63;

   typedef struct packed {
      logic                 of;
      logic [EVT_SEL_W-1:0] sel;
   } hpm_evt_t;

   // CSR image of an mhpmevent register; every bit besides sel and OF reads 0.
   function automatic logic [63:0] evt_to_csr(input hpm_evt_t e);
      logic [63:0] r;
      r                  = '0;
      r[EVT_OF_BIT]      = e.of;
      r[EVT_SEL_W-1:0]   = e.sel;
      return r;
   endfunction

endpackage

// File: rtl/hpm_counter.sv
// One CNT_WIDTH counter with a CSR write port, an increment enable and a
// sticky overflow flag. A CSR write to the counter suppresses the increment
// (and hence any wrap); a wrap beats a software write of the flag.
module hpm_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_cnt_we,
   input  logic [CNT_WIDTH-1:0] i_cnt_wdata,
   input  logic                 i_inc,
   input  logic                 i_of_we,
   input  logic                 i_of_wdata,
   output logic [CNT_WIDTH-1:0] o_cnt,
   output logic                 o_of
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 of_q, of_d;
   logic                 wrap;

   // next count and overflow flag with write/increment/wrap priority
   always_comb begin
      wrap  = i_inc && !i_cnt_we && (&cnt_q);
      cnt_d = cnt_q;
      if (i_cnt_we) begin
         cnt_d = i_cnt_wdata;
      end else if (i_inc) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      of_d = of_q;
      if (wrap) begin
         of_d = 1'b1;
      end else if (i_of_we) begin
         of_d = i_of_wdata;
      end
   end

   // counter and flag registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
         of_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         of_q  <= of_d;
      end
   end

   assign o_cnt = cnt_q;
   assign o_of  = of_q;

endmodule

// File: rtl/csr_hpm_counters.sv
// Machine counter / performance-monitor CSR bank: mcycle, minstret,
// NUM_HPM event counters with selectors, mcountinhibit, sticky overflow
// flags and the local-count-overflow interrupt.
module csr_hpm_counters
   import csr_hpm_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int NUM_HPM    = 4,
   parameter int CNT_WIDTH  = 64,
   parameter int NUM_EVENTS = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [11:0]           i_csr_addr,
   input  logic [XLEN-1:0]       i_csr_wdata,
   input  logic                  i_csr_we,
   input  logic                  i_csr_re,
   output logic [XLEN-1:0]       o_csr_rdata,
   output logic                  o_csr_hit,
   output logic                  o_csr_ro,
   input  logic                  i_retire,
   input  logic [NUM_EVENTS-1:0] i_events,
   input  logic                  i_halted,
   output logic                  o_lcofi
);

   // keeps array declarations legal when no HPM counters are built
   localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;

   logic                 cy_inh_q, ir_inh_q;
   logic [NH-1:0]        hpm_inh_q;
   logic [CNT_WIDTH-1:0] cy_cnt, ir_cnt;
   logic [CNT_WIDTH-1:0] hpm_cnt [NH];
   logic [EVT_SEL_W-1:0] evt_sel [NH];
   logic [NH-1:0]        hpm_of;
   logic                 cy_of_unused, ir_of_unused;
   logic                 wr_ok, count_en, inh_we;
   logic [255:0]         ev_ext;
   logic [XLEN-1:0]      rd_val;
   logic [XLEN-1:0]      rdata_q;
   logic                 lcofi_q;

   assign wr_ok    = i_csr_we && o_csr_hit && !o_csr_ro;
   assign count_en = !i_halted;
   assign inh_we   = wr_ok && (i_csr_addr == CSR_MCOUNTINHIBIT);
   assign o_csr_ro = (i_csr_addr[11:5] == 7'h60);

   // bit 0 is the "no event" slot so sel=0 and sel>NUM_EVENTS index zeros
   assign ev_ext = 256'({i_events, 1'b0});

   hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_cnt_we    (wr_ok && (i_csr_addr == CSR_MCYCLE)),
      .i_cnt_wdata (i_csr_wdata[CNT_WIDTH-1:0]),
      .i_inc       (count_en && !cy_inh_q),
      .i_of_we     (1'b0),
      .i_of_wdata  (1'b0),
      .o_cnt       (cy_cnt),
      .o_of        (cy_of_unused)
   );

   hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_cnt_we    (wr_ok && (i_csr_addr == CSR_MINSTRET)),
      .i_cnt_wdata (i_csr_wdata[CNT_WIDTH-1:0]),
      .i_inc       (count_en && i_retire && !ir_inh_q),
      .i_of_we     (1'b0),
      .i_of_wdata  (1'b0),
      .o_cnt       (ir_cnt),
      .o_of        (ir_of_unused)
   );

   generate
      if (NUM_HPM > 0) begin : g_hpm
         for (genvar k = 0; k < NUM_HPM; k++) begin : g_ctr
            logic                 cnt_we, evt_we, inc;
            logic [EVT_SEL_W-1:0] sel_q;

            assign cnt_we = wr_ok && (i_csr_addr == CSR_MHPMCNT_BASE + 12'(k));
            assign evt_we = wr_ok && (i_csr_addr == CSR_MHPMEVT_BASE + 12'(k));
            assign inc    = count_en && !hpm_inh_q[k] && ev_ext[sel_q];

            // event selector field of mhpmevent
            always_ff @(posedge i_clk or negedge i_reset_n) begin
               if (!i_reset_n) begin
                  sel_q <= '0;
               end else if (evt_we) begin
                  sel_q <= i_csr_wdata[EVT_SEL_W-1:0];
               end
            end

            assign evt_sel[k] = sel_q;

            hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hpm (
               .i_clk       (i_clk),
               .i_reset_n   (i_reset_n),
               .i_cnt_we    (cnt_we),
               .i_cnt_wdata (i_csr_wdata[CNT_WIDTH-1:0]),
               .i_inc       (inc),
               .i_of_we     (evt_we),
               .i_of_wdata  (i_csr_wdata[EVT_OF_BIT]),
               .o_cnt       (hpm_cnt[k]),
               .o_of        (hpm_of[k])
            );
         end
      end else begin : g_no_hpm
         assign evt_sel[0] = '0;
         assign hpm_cnt[0] = '0;
         assign hpm_of     = '0;
      end
   endgenerate

   // mcountinhibit; new bits gate counting from the following cycle
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cy_inh_q  <= 1'b0;
         ir_inh_q  <= 1'b0;
         hpm_inh_q <= '0;
      end else if (inh_we) begin
         cy_inh_q <= i_csr_wdata[0];
         ir_inh_q <= i_csr_wdata[2];
         for (int k = 0; k < NUM_HPM; k++) begin
            hpm_inh_q[k] <= i_csr_wdata[3+k];
         end
      end
   end

   // address decode and read mux; misses return 0
   always_comb begin
      o_csr_hit = 1'b0;
      rd_val    = '0;
      case (i_csr_addr)
         CSR_MCYCLE, CSR_CYCLE: begin
            o_csr_hit = 1'b1;
            rd_val    = XLEN'(cy_cnt);
         end
         CSR_MINSTRET, CSR_INSTRET: begin
            o_csr_hit = 1'b1;
            rd_val    = XLEN'(ir_cnt);
         end
         CSR_MCOUNTINHIBIT: begin
            o_csr_hit = 1'b1;
            rd_val[0] = cy_inh_q;
            rd_val[2] = ir_inh_q;
            for (int k = 0; k < NUM_HPM; k++) begin
               rd_val[3+k] = hpm_inh_q[k];
            end
         end
         default: ;
      endcase
      for (int k = 0; k < NUM_HPM; k++) begin
         if ((i_csr_addr == CSR_MHPMCNT_BASE + 12'(k)) ||
             (i_csr_addr == CSR_HPMCNT_BASE + 12'(k))) begin
            o_csr_hit = 1'b1;
            rd_val    = XLEN'(hpm_cnt[k]);
         end
         if (i_csr_addr == CSR_MHPMEVT_BASE + 12'(k)) begin
            o_csr_hit = 1'b1;
            rd_val    = XLEN'(evt_to_csr(hpm_evt_t'{of: hpm_of[k], sel: evt_sel[k]}));
         end
      end
   end

   // registered read data and overflow interrupt
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rdata_q <= '0;
         lcofi_q <= 1'b0;
      end else begin
         if (i_csr_re) begin
            rdata_q <= rd_val;
         end
         lcofi_q <= |hpm_of;
      end
   end

   assign o_csr_rdata = rdata_q;
   assign o_lcofi     = lcofi_q;

endmodule
